// File: rtl/yuv_to_rgb_controller_if.sv
// Controller <-> datapath/memory bus: frame memory req/gnt, write strobe,
// capture enables, mux selects and counter controls.
interface yuv_to_rgb_controller_if;
  logic       mem_req;
  logic       mem_gnt;
  logic       mem_we;
  logic       cmp;
  logic       clear;
  logic       eny1, enu1, env1;
  logic       eny2, enu2, env2;
  logic [1:0] smuxra;
  logic [1:0] smuxop1;
  logic       smuxop2;
  logic       smuxop3;
  logic       inc1;
  logic       inc2;

  modport master (
    output mem_req, mem_we, clear,
    output eny1, enu1, env1, eny2, enu2, env2,
    output smuxra, smuxop1, smuxop2, smuxop3, inc1, inc2,
    input  mem_gnt, cmp
  );

  modport slave (
    input  mem_req, mem_we, clear,
    input  eny1, enu1, env1, eny2, enu2, env2,
    input  smuxra, smuxop1, smuxop2, smuxop3, inc1, inc2,
    output mem_gnt, cmp
  );
endinterface

// File: rtl/yuv_to_rgb_controller.sv
// Moore FSM sequencing the YUV->RGB datapath one 9-cycle memory burst per pixel pair.
// Optional YUV_CTRL_PERF_EN adds a saturating grant-stall counter output.
module yuv_to_rgb_controller #(
  parameter int RELEASE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
`ifdef YUV_CTRL_PERF_EN
  output logic [31:0] stall_cycles,
`endif
  yuv_to_rgb_controller_if.master bus
);

  localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, CLR, REQ, RY, RU, RV, C0, C1, C2, C3, C4, C5, REL, DONE
  } state_t;

  typedef struct packed {
    logic       busy, done, mem_req, mem_we, clear;
    logic       ey, eu, ev;
    logic [1:0] ra, op1;
    logic       op2, op3, inc1, inc2;
  } out_t;

  state_t        state, nxt;
  out_t          o;
  logic [RW-1:0] rel_cnt;

  // Outputs are a pure function of state; registering decode(nxt) keeps them glitch-free.
  function automatic out_t decode(state_t s);
    out_t d;
    d = '0;
    d.busy    = (s != IDLE);
    d.mem_req = (s inside {REQ, RY, RU, RV, C0, C1, C2, C3, C4, C5});
    case (s)
      CLR:  d.clear = 1'b1;
      RU:   begin d.ey = 1'b1; d.ra = 2'b01; end
      RV:   begin d.eu = 1'b1; d.ra = 2'b10; end
      C0:   d.ev = 1'b1;
      C1:   begin d.op3 = 1'b1; d.op1 = 2'b01; d.mem_we = 1'b1; d.inc2 = 1'b1; end
      C2:   begin d.op3 = 1'b1; d.op1 = 2'b10; end
      C3:   begin d.op3 = 1'b1; d.op2 = 1'b1; d.mem_we = 1'b1; d.inc2 = 1'b1; end
      C4:   begin d.op3 = 1'b1; d.op2 = 1'b1; d.op1 = 2'b01; end
      C5:   begin
        d.op3 = 1'b1; d.op2 = 1'b1; d.op1 = 2'b10;
        d.mem_we = 1'b1; d.inc2 = 1'b1; d.inc1 = 1'b1;
      end
      DONE: d.done = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = CLR;
      CLR:  nxt = REQ;
      REQ:  if (bus.mem_gnt) nxt = RY;
      RY:   nxt = RU;
      RU:   nxt = RV;
      RV:   nxt = C0;
      C0:   nxt = C1;
      C1:   nxt = C2;
      C2:   nxt = C3;
      C3:   nxt = C4;
      C4:   nxt = C5;
      C5:   nxt = bus.cmp ? DONE : REL;
      REL:  if (rel_cnt == '0) nxt = REQ;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      o       <= '0;
      rel_cnt <= '0;
    end else begin
      state <= nxt;
      o     <= decode(nxt);
      if (nxt == REL && state != REL)
        rel_cnt <= RW'(RELEASE_CYCLES - 1);
      else if (state == REL && rel_cnt != '0)
        rel_cnt <= rel_cnt - 1'b1;
    end
  end

`ifdef YUV_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (state == CLR)
      stall_cycles <= '0;
    else if (state == REQ && !bus.mem_gnt && stall_cycles != '1)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

  assign busy        = o.busy;
  assign done        = o.done;
  assign bus.mem_req = o.mem_req;
  assign bus.mem_we  = o.mem_we;
  assign bus.clear   = o.clear;
  assign bus.eny1    = o.ey;
  assign bus.eny2    = o.ey;
  assign bus.enu1    = o.eu;
  assign bus.enu2    = o.eu;
  assign bus.env1    = o.ev;
  assign bus.env2    = o.ev;
  assign bus.smuxra  = o.ra;
  assign bus.smuxop1 = o.op1;
  assign bus.smuxop2 = o.op2;
  assign bus.smuxop3 = o.op3;
  assign bus.inc1    = o.inc1;
  assign bus.inc2    = o.inc2;

endmodule

// File: tb/tb_yuv_to_rgb_controller.sv
// Trace-based bench: frames are expanded from the burst schedule into a per-cycle
// table of stimulus and expected outputs, then replayed against the controller.
module tb_yuv_to_rgb_controller;
  localparam int RC = 3;

  typedef enum {P_IDLE, P_CLR, P_REQ, P_RY, P_RU, P_RV, P_C0, P_C1, P_C2,
                P_C3, P_C4, P_C5, P_REL, P_DONE} phase_t;

  typedef struct {
    phase_t      p;
    logic        rst, start, gnt, cmp;
    int unsigned stall;
  } row_t;

  logic clk = 1'b0;
  logic rst, start, busy, done;
`ifdef YUV_CTRL_PERF_EN
  logic [31:0] stall_cycles;
`endif
  row_t        rows[$];
  int unsigned acc;
  int          ntot = 0, npass = 0;

  always #5 clk = ~clk;

  yuv_to_rgb_controller_if bus();

  yuv_to_rgb_controller #(.RELEASE_CYCLES(RC)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
`ifdef YUV_CTRL_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .bus   (bus)
  );

  wire [18:0] obs = {busy, done, bus.mem_req, bus.mem_we, bus.clear,
                     bus.eny1, bus.enu1, bus.env1, bus.eny2, bus.enu2, bus.env2,
                     bus.smuxra, bus.smuxop1, bus.smuxop2, bus.smuxop3, bus.inc1, bus.inc2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got %h want %h", tag, got, exp);
  endtask

  function automatic logic [18:0] mk(bit b, bit d, bit rq, bit we, bit cl, bit ey, bit eu,
                                     bit ev, bit [1:0] ra, bit [1:0] op1, bit op2,
                                     bit op3, bit i1, bit i2);
    return {b, d, rq, we, cl, ey, eu, ev, ey, eu, ev, ra, op1, op2, op3, i1, i2};
  endfunction

  // Expected outputs per phase, straight from the output table of the controller.
  function automatic logic [18:0] ph(phase_t p);
    case (p)
      P_CLR:  return mk(1,0,0,0,1, 0,0,0, 2'b00, 2'b00, 0,0,0,0);
      P_REQ:  return mk(1,0,1,0,0, 0,0,0, 2'b00, 2'b00, 0,0,0,0);
      P_RY:   return mk(1,0,1,0,0, 0,0,0, 2'b00, 2'b00, 0,0,0,0);
      P_RU:   return mk(1,0,1,0,0, 1,0,0, 2'b01, 2'b00, 0,0,0,0);
      P_RV:   return mk(1,0,1,0,0, 0,1,0, 2'b10, 2'b00, 0,0,0,0);
      P_C0:   return mk(1,0,1,0,0, 0,0,1, 2'b00, 2'b00, 0,0,0,0);
      P_C1:   return mk(1,0,1,1,0, 0,0,0, 2'b00, 2'b01, 0,1,0,1);
      P_C2:   return mk(1,0,1,0,0, 0,0,0, 2'b00, 2'b10, 0,1,0,0);
      P_C3:   return mk(1,0,1,1,0, 0,0,0, 2'b00, 2'b00, 1,1,0,1);
      P_C4:   return mk(1,0,1,0,0, 0,0,0, 2'b00, 2'b01, 1,1,0,0);
      P_C5:   return mk(1,0,1,1,0, 0,0,0, 2'b00, 2'b10, 1,1,1,1);
      P_REL:  return mk(1,0,0,0,0, 0,0,0, 2'b00, 2'b00, 0,0,0,0);
      P_DONE: return mk(1,1,0,0,0, 0,0,0, 2'b00, 2'b00, 0,0,0,0);
      default: return '0;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Stall counter value is what the cycle shows; this row's effect lands next cycle.
  task automatic add(input phase_t p, input logic st, input logic g, input logic c,
                     input logic r);
    row_t w;
    w.p = p; w.rst = r; w.start = st; w.gnt = g; w.cmp = c; w.stall = acc;
    rows.push_back(w);
    if (r) acc = 0;
    else if (p == P_CLR) acc = 0;
    else if (p == P_REQ && !g) acc++;
  endtask

  task automatic idle(input int n);
    repeat (n) add(P_IDLE, 1'b0, rb(), rb(), 1'b0);
  endtask

  // One frame of nb bursts; abort_b >= 0 pulses reset during that burst's C3.
  task automatic frame(input int nb, input bit b2b, input int abort_b, input int first_wait);
    int k;
    add(P_IDLE, 1'b1, rb(), rb(), 1'b0);
    add(P_CLR, rb(), rb(), rb(), 1'b0);
    for (int b = 0; b < nb; b++) begin
      k = (b == 0 && first_wait >= 0) ? first_wait : int'($urandom_range(0, 3));
      repeat (k) add(P_REQ, rb(), 1'b0, rb(), 1'b0);
      add(P_REQ, rb(), 1'b1, rb(), 1'b0);
      add(P_RY, rb(), 1'b1, rb(), 1'b0);
      add(P_RU, rb(), 1'b1, rb(), 1'b0);
      add(P_RV, rb(), 1'b1, rb(), 1'b0);
      add(P_C0, rb(), 1'b1, rb(), 1'b0);
      add(P_C1, rb(), 1'b1, rb(), 1'b0);
      add(P_C2, rb(), 1'b1, rb(), 1'b0);
      if (b == abort_b) begin
        add(P_C3, 1'b0, 1'b1, rb(), 1'b1);
        add(P_IDLE, 1'b0, rb(), rb(), 1'b1);
        add(P_IDLE, 1'b0, rb(), rb(), 1'b0);
        return;
      end
      add(P_C3, rb(), 1'b1, rb(), 1'b0);
      add(P_C4, rb(), 1'b1, rb(), 1'b0);
      add(P_C5, rb(), 1'b1, (b == nb - 1), 1'b0);
      if (b == nb - 1) add(P_DONE, b2b, rb(), rb(), 1'b0);
      else repeat (RC) add(P_REL, rb(), rb(), rb(), 1'b0);
    end
  endtask

  initial begin
    int nwe, nexp;
    rst = 1'b1; start = 1'b0; bus.mem_gnt = 1'b0; bus.cmp = 1'b0;
    acc = 0;

    idle(2);
    frame(4, 1'b0, -1, 5);
    idle(3);
    frame(4, 1'b1, -1, -1);
    frame(4, 1'b0, -1, 0);
    idle(2);
    frame(3, 1'b0, 1, -1);
    idle(2);
    repeat (4) begin
      frame(int'($urandom_range(1, 5)), 1'b0, -1, -1);
      idle(int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    nwe = 0; nexp = 0;
    foreach (rows[i]) begin
      @(posedge clk); #1;
      chk($sformatf("out@%0d", i), 32'(obs), 32'(ph(rows[i].p)));
`ifdef YUV_CTRL_PERF_EN
      chk($sformatf("stall@%0d", i), stall_cycles, rows[i].stall);
`endif
      nwe  += int'(bus.mem_we);
      nexp += int'(rows[i].p inside {P_C1, P_C3, P_C5});
      rst         = rows[i].rst;
      start       = rows[i].start;
      bus.mem_gnt = rows[i].gnt;
      bus.cmp     = rows[i].cmp;
    end
    chk("we_total", nwe, nexp);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
